// File: rtl/mult_controller.sv
// ---------------------------------------------------------------------------
// mult_controller
//   Sequencing FSM for an 8-bit signed add-shift multiplier. It drives the
//   9-bit add/subtract adder selects, the X/A/B register clears and loads,
//   and the X:A:B arithmetic right shift. A run performs N_BITS
//   add-then-shift iterations. The last iteration subtracts the
//   multiplicand, which gives a correct two's-complement product.
//
// Parameters
//   N_BITS        multiplier width and iteration count (>= 2)
//
// Ports
//   Clk           in   system clock; all state changes occur on the rising edge
//   Reset         in   synchronous, active-high reset
//   Run           in   level start request (already debounced)
//   ClearA_LoadB  in   request, honoured in IDLE only: clear X/A and load B
//   M             in   current multiplier bit (B[0])
//   Clr_XA        out  clear X and A on this edge
//   Ld_B          out  load B from the switches on this edge
//   Ld_XA         out  load adder result into {X,A} on this edge
//   Add           out  adder add select
//   Sub           out  adder subtract select
//   Shift_En      out  arithmetic right shift of X:A:B on this edge
//   Busy          out  high in CLEAR, CALC and SHIFT
//   Done          out  high in HOLD
// ---------------------------------------------------------------------------
module mult_controller #(
  parameter int N_BITS = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Ld_XA,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_CALC  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_iter;

  assign last_iter = (cnt_reg == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (Run) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_next   = '0;
        state_next = ST_CALC;
      end
      ST_CALC: begin
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_iter) begin
          state_next = ST_HOLD;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_HOLD: begin
        // Leaving only on Run low means a held Run cannot start a second run.
        if (!Run) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode. Shift_En depends on the state alone, so changes on cnt
  // cannot glitch it. Add and Sub are mutually exclusive through last_iter.
  always_comb begin
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_XA    = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Run takes priority over the clear/load request. A reset edge
        // must not load the datapath either.
        Clr_XA = ClearA_LoadB & ~Run & ~Reset;
        Ld_B   = ClearA_LoadB & ~Run & ~Reset;
      end
      ST_CLEAR: begin
        Clr_XA = 1'b1;
        Busy   = 1'b1;
      end
      ST_CALC: begin
        Ld_XA = M;
        Add   = M & ~last_iter;
        Sub   = M & last_iter;
        Busy  = 1'b1;
      end
      ST_SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      ST_HOLD: begin
        Done = 1'b1;
      end
      default: begin
        Clr_XA = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_controller.sv
// ---------------------------------------------------------------------------
// tb_mult_controller
//   Directed bench for mult_controller with N_BITS = 8. A small X/A/B
//   datapath model is driven by the controller strobes, so the bench can
//   check the final products. The strobe bundle is compared as one 8-bit
//   vector in this order:
//   {Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Busy, Done}
// ---------------------------------------------------------------------------
module tb_mult_controller;

  logic Clk;
  logic Reset;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Busy, Done;

  int vectors;
  int miscompares;

  // Datapath model
  logic       x_m;
  logic [7:0] a_m;
  logic [7:0] b_m;
  logic [7:0] sw_b;
  logic [7:0] mcand;

  mult_controller #(.N_BITS(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_XA       (Clr_XA),
    .Ld_B         (Ld_B),
    .Ld_XA        (Ld_XA),
    .Add          (Add),
    .Sub          (Sub),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign M = b_m[0];

  always @(posedge Clk) begin
    if (Ld_B) b_m <= sw_b;
    if (Clr_XA) begin
      x_m <= 1'b0;
      a_m <= 8'h00;
    end else if (Ld_XA) begin
      if (Sub) {x_m, a_m} <= {x_m, a_m} - {mcand[7], mcand};
      else     {x_m, a_m} <= {x_m, a_m} + {mcand[7], mcand};
    end
    if (Shift_En) begin
      a_m <= {x_m, a_m[7:1]};
      b_m <= {a_m[0], b_m[7:1]};
    end
  end

  function automatic logic [7:0] strobes();
    return {Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Busy, Done};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  // Load B in IDLE, then run one full multiply. Every cycle is checked
  // against the timing of the run. Cycle 0 is the IDLE cycle in which Run
  // is sampled. With hold_run = 1, the task returns in HOLD with Run still
  // high. Otherwise it drops Run, checks the return to IDLE and checks the
  // product.
  task automatic run_multiply(input logic [7:0] s, input logic [7:0] b,
                              input logic [15:0] exp_prod, input logic hold_run);
    logic [7:0] exp_v;
    logic       calc, mb;
    int         it;
    sw_b = b;
    mcand = s;
    ClearA_LoadB = 1'b1;
    Run = 1'b0;
    tick();
    ClearA_LoadB = 1'b0;
    Run = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      calc = (c >= 2) && (c <= 16) && (c % 2 == 0);
      it = calc ? (c - 2) / 2 : 0;
      mb = calc ? b[it] : 1'b0;
      exp_v = {(c == 1), 1'b0, mb, mb & (it < 7), mb & (it == 7),
               (c >= 3) && (c <= 17) && (c % 2 == 1),
               (c >= 1) && (c <= 17), (c == 18)};
      vectors++;
      if (strobes() !== exp_v) begin
        miscompares++;
        $display("FAIL run_cycle%0d S=%h B=%h strobes got %b want %b", c, s, b, strobes(), exp_v);
      end
      // A Run drop mid-operation must be ignored.
      if (!hold_run && c == 1) Run = 1'b0;
    end
    if (!hold_run) begin
      Run = 1'b0;
      tick();
      vectors++;
      if (strobes() !== 8'h00) begin
        miscompares++;
        $display("FAIL run_exit S=%h B=%h strobes got %b want 00000000", s, b, strobes());
      end
      vectors++;
      if ({a_m, b_m} !== exp_prod) begin
        miscompares++;
        $display("FAIL product S=%h B=%h got %h want %h", s, b, {a_m, b_m}, exp_prod);
      end
      $display("run S=%h B=%h -> A:B=%h (expected %h)", s, b, {a_m, b_m}, exp_prod);
    end
  endtask

  task automatic test_reset();
    // Start a run and reach an arbitrary mid-run state.
    Run = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    Reset = 1'b1;
    Run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (strobes() !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_idle%0d strobes got %b want 00000000", k, strobes());
      end
    end
    Reset = 1'b0;
    Run = 1'b1;
    #1;
    vectors++;
    if (strobes() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_run_sampled strobes got %b want 00000000", strobes());
    end
    tick();
    vectors++;
    if (strobes() !== 8'b1000_0010) begin
      miscompares++;
      $display("FAIL reset_then_clear strobes got %b want 10000010", strobes());
    end
    $display("test_reset done");
    do_reset();
  endtask

  task automatic test_clear_load();
    ClearA_LoadB = 1'b1;
    Run = 1'b0;
    #1;
    vectors++;
    if (strobes() !== 8'b1100_0000) begin
      miscompares++;
      $display("FAIL idle_clear_load strobes got %b want 11000000", strobes());
    end
    Reset = 1'b1;
    #1;
    vectors++;
    if (strobes() !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_load_in_reset strobes got %b want 00000000", strobes());
    end
    Reset = 1'b0;
    Run = 1'b1;
    #1;
    vectors++;
    if (strobes() !== 8'h00) begin
      miscompares++;
      $display("FAIL run_wins strobes got %b want 00000000", strobes());
    end
    tick();
    vectors++;
    if (strobes() !== 8'b1000_0010) begin
      miscompares++;
      $display("FAIL run_wins_clear strobes got %b want 10000010", strobes());
    end
    tick();
    vectors++;
    if ({Clr_XA, Ld_B, Busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL clear_load_outside_idle {Clr_XA,Ld_B,Busy} got %b want 001", {Clr_XA, Ld_B, Busy});
    end
    $display("test_clear_load done");
    do_reset();
  endtask

  task automatic test_add_pattern();
    run_multiply(8'h05, 8'h07, 16'h0023, 1'b0);
  endtask

  task automatic test_products();
    run_multiply(8'h07, 8'hFF, 16'hFFF9, 1'b0);
    run_multiply(8'hFF, 8'hFF, 16'h0001, 1'b0);
    run_multiply(8'h80, 8'h80, 16'h4000, 1'b0);
  endtask

  task automatic test_hold();
    run_multiply(8'h03, 8'h02, 16'h0006, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (strobes() !== 8'b0000_0001) begin
        miscompares++;
        $display("FAIL hold%0d strobes got %b want 00000001", k, strobes());
      end
    end
    Run = 1'b0;
    tick();
    vectors++;
    if (strobes() !== 8'h00) begin
      miscompares++;
      $display("FAIL hold_exit strobes got %b want 00000000", strobes());
    end
    Run = 1'b1;
    tick();
    vectors++;
    if (strobes() !== 8'b1000_0010) begin
      miscompares++;
      $display("FAIL hold_restart strobes got %b want 10000010", strobes());
    end
    $display("test_hold done");
    do_reset();
  endtask

  task automatic test_abort();
    Run = 1'b1;
    for (int c = 1; c <= 9; c++) tick();
    vectors++;
    if (strobes() !== 8'b0000_0110) begin
      miscompares++;
      $display("FAIL abort_cycle9_shift strobes got %b want 00000110", strobes());
    end
    Reset = 1'b1;
    Run = 1'b0;
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (strobes() !== 8'h00) begin
        miscompares++;
        $display("FAIL abort_idle%0d strobes got %b want 00000000", k, strobes());
      end
      tick();
    end
    $display("test_abort reset taken");
    run_multiply(8'h03, 8'hFD, 16'hFFF7, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    sw_b = 8'h00;
    mcand = 8'h00;
    x_m = 1'b0;
    a_m = 8'h00;
    b_m = 8'h00;
    tick();
    tick();
    Reset = 1'b0;
    test_reset();
    test_clear_load();
    test_add_pattern();
    test_products();
    test_hold();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
